// File: rtl/user_obi_router.sv
// OBI subordinate router: rule-table decode to NumPorts downstream ports plus an
// internal error target, in-order response tracking and a per-transaction watchdog.
module user_obi_router #(
    parameter int unsigned                       NumPorts      = 4,
    parameter int unsigned                       NumRules      = 4,
    parameter logic [NumRules-1:0][31:0]         RuleStart     = {32'h5000_0000, 32'h4000_0000,
                                                                  32'h1000_0000, 32'h2000_0000},
    parameter logic [NumRules-1:0][31:0]         RuleEnd       = {32'h5000_1000, 32'h4000_1000,
                                                                  32'h1000_1000, 32'h2000_1000},
    parameter logic [NumRules-1:0][7:0]          RuleIdx       = {8'd3, 8'd2, 8'd0, 8'd1},
    parameter int unsigned                       IdWidth       = 1,
    parameter int unsigned                       MaxTrans      = 2,
    parameter int unsigned                       TimeoutCycles = 64,
    parameter logic [31:0]                       ErrData       = 32'hBADCAB1E,
    parameter logic [31:0]                       TimeoutData   = 32'h0BADF00D,
    localparam int unsigned                      PortW         = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sbr_req_i,
    input  logic                         sbr_we_i,
    input  logic [31:0]                  sbr_addr_i,
    input  logic [31:0]                  sbr_wdata_i,
    input  logic [3:0]                   sbr_be_i,
    input  logic [IdWidth-1:0]           sbr_aid_i,
    output logic                         sbr_gnt_o,
    output logic                         sbr_rvalid_o,
    output logic                         sbr_err_o,
    output logic [31:0]                  sbr_rdata_o,
    output logic [IdWidth-1:0]           sbr_rid_o,
    output logic [NumPorts-1:0]          mgr_req_o,
    input  logic [NumPorts-1:0]          mgr_gnt_i,
    output logic [31:0]                  mgr_addr_o,
    output logic [31:0]                  mgr_wdata_o,
    output logic                         mgr_we_o,
    output logic [3:0]                   mgr_be_o,
    output logic [IdWidth-1:0]           mgr_aid_o,
    input  logic [NumPorts-1:0]          mgr_rvalid_i,
    input  logic [NumPorts-1:0]          mgr_err_i,
    input  logic [NumPorts-1:0][31:0]    mgr_rdata_i,
    output logic                         timeout_irq_o,
    output logic [PortW-1:0]             timeout_port_o
);

    localparam int unsigned    TgtW    = $clog2(NumPorts + 1);
    localparam logic [TgtW-1:0] TgtErr = TgtW'(NumPorts);
    localparam int unsigned    PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned    CntW    = $clog2(MaxTrans + 1);
    localparam int unsigned    WdW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdW-1:0] WdLimit = (TimeoutCycles > 0) ? WdW'(TimeoutCycles - 1) : '0;

    logic [TgtW-1:0]          r_fifo_tgt [MaxTrans];
    logic [IdWidth-1:0]       r_fifo_aid [MaxTrans];
    logic [PtrW-1:0]          r_rd_ptr;
    logic [PtrW-1:0]          r_wr_ptr;
    logic [CntW-1:0]          r_cnt;
    logic [TgtW-1:0]          r_last_tgt;
    logic [WdW-1:0]           r_wdog;
    logic [NumPorts-1:0][3:0] r_disc;
    logic [PortW-1:0]         r_timeout_port;

    logic [TgtW-1:0]     w_dec_tgt;
    logic [PortW-1:0]    w_dec_port;
    logic                w_dec_err;
    logic                w_empty;
    logic                w_full;
    logic                w_allowed;
    logic                w_fwd;
    logic                w_push;
    logic                w_pop;
    logic [PtrW-1:0]     w_rd_ptr_nxt;
    logic [PtrW-1:0]     w_wr_ptr_nxt;
    logic [TgtW-1:0]     w_head_tgt;
    logic [IdWidth-1:0]  w_head_aid;
    logic [PortW-1:0]    w_head_port;
    logic                w_head_err;
    logic                w_head_real;
    logic                w_real_resp;
    logic                w_timeout;
    logic [NumPorts-1:0] w_swallow;
    logic [NumPorts-1:0] w_disc_inc;

    // Scan from the highest rule down so the lowest-numbered match is the last write.
    always_comb begin
        w_dec_tgt = TgtErr;
        for (int r = NumRules - 1; r >= 0; r--) begin
            if ((sbr_addr_i >= RuleStart[r]) && (sbr_addr_i < RuleEnd[r])) begin
                w_dec_tgt = TgtW'(RuleIdx[r]);
            end
        end
    end

    assign w_dec_err  = (w_dec_tgt == TgtErr);
    assign w_dec_port = w_dec_tgt[PortW-1:0];
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CntW'(MaxTrans));
    assign w_allowed  = rst_ni && !w_full && (w_empty || (w_dec_tgt == r_last_tgt));
    assign w_fwd      = sbr_req_i && w_allowed && !w_dec_err;

    always_comb begin
        mgr_req_o = '0;
        if (w_fwd) begin
            mgr_req_o[w_dec_port] = 1'b1;
        end
    end

    assign sbr_gnt_o   = sbr_req_i && w_allowed && (w_dec_err || mgr_gnt_i[w_dec_port]);
    assign mgr_addr_o  = w_fwd ? sbr_addr_i  : '0;
    assign mgr_wdata_o = w_fwd ? sbr_wdata_i : '0;
    assign mgr_we_o    = w_fwd && sbr_we_i;
    assign mgr_be_o    = w_fwd ? sbr_be_i    : '0;
    assign mgr_aid_o   = w_fwd ? sbr_aid_i   : '0;

    assign w_head_tgt  = r_fifo_tgt[r_rd_ptr];
    assign w_head_aid  = r_fifo_aid[r_rd_ptr];
    assign w_head_port = w_head_tgt[PortW-1:0];
    assign w_head_err  = !w_empty && (w_head_tgt == TgtErr);
    assign w_head_real = !w_empty && (w_head_tgt != TgtErr);

    always_comb begin
        w_swallow  = '0;
        w_disc_inc = '0;
        for (int p = 0; p < NumPorts; p++) begin
            w_swallow[p]  = mgr_rvalid_i[p] && (r_disc[p] != 4'd0);
            w_disc_inc[p] = w_timeout && (w_head_port == PortW'(p)) && (r_disc[p] != 4'hF);
        end
    end

    // A genuine response in the would-be timeout cycle takes precedence.
    assign w_real_resp = w_head_real && mgr_rvalid_i[w_head_port] && !w_swallow[w_head_port];
    assign w_timeout   = (TimeoutCycles != 0) && w_head_real && !w_real_resp && (r_wdog == WdLimit);
    assign w_pop       = w_real_resp || w_head_err || w_timeout;
    assign w_push      = sbr_gnt_o;

    assign w_rd_ptr_nxt = (r_rd_ptr == PtrW'(MaxTrans - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_ptr_nxt = (r_wr_ptr == PtrW'(MaxTrans - 1)) ? '0 : r_wr_ptr + 1'b1;

    always_comb begin
        sbr_rvalid_o = w_pop;
        sbr_err_o    = 1'b0;
        sbr_rdata_o  = '0;
        sbr_rid_o    = '0;
        if (w_pop) begin
            sbr_rid_o = w_head_aid;
            if (w_head_err) begin
                sbr_err_o   = 1'b1;
                sbr_rdata_o = ErrData;
            end else if (w_real_resp) begin
                sbr_err_o   = mgr_err_i[w_head_port];
                sbr_rdata_o = mgr_rdata_i[w_head_port];
            end else begin
                sbr_err_o   = 1'b1;
                sbr_rdata_o = TimeoutData;
            end
        end
    end

    assign timeout_irq_o  = w_timeout;
    assign timeout_port_o = r_timeout_port;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_last_tgt <= '0;
            for (int i = 0; i < MaxTrans; i++) begin
                r_fifo_tgt[i] <= '0;
                r_fifo_aid[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_tgt[r_wr_ptr] <= w_dec_tgt;
                r_fifo_aid[r_wr_ptr] <= sbr_aid_i;
                r_wr_ptr             <= w_wr_ptr_nxt;
                r_last_tgt           <= w_dec_tgt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= '0;
        end else if (w_pop || w_empty) begin
            r_wdog <= '0;
        end else if (w_head_real) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_disc         <= '0;
            r_timeout_port <= '0;
        end else begin
            if (w_timeout) begin
                r_timeout_port <= w_head_port;
            end
            for (int p = 0; p < NumPorts; p++) begin
                if (w_disc_inc[p] && !w_swallow[p]) begin
                    r_disc[p] <= r_disc[p] + 4'd1;
                end else if (w_swallow[p] && !w_disc_inc[p]) begin
                    r_disc[p] <= r_disc[p] - 4'd1;
                end
            end
        end
    end

endmodule
